mc_control: RTL and testbench



---
 rtl/mc_pkg.sv | 57 +++++
 rtl/mc_decode.sv | 64 ++++++
 rtl/mc_control.sv | 164 ++++++++++++++++
 tb/tb_mc_control.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared opcode, ALU-op, state and instruction-class definitions for the
// multi-cycle MIPS sequencing controller.
package mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_OR    = 2'b11;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        TRAP
    } state_t;

    typedef enum logic [3:0] {
        RTYPE,
        LOAD,
        STORE,
        ADDI,
        ORI,
        BRANCH_EQ,
        BRANCH_NE,
        JUMP,
        ILLEGAL
    } iclass_t;

    typedef struct packed {
        logic       alu_src;
        logic [1:0] alu_op;
        logic       jump;
        logic       beq;
        logic       bne;
        logic       ext_op;
        logic       reg_dst;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

    // Control-flow classes finish in EXEC; everything else needs MEM and/or WB.
    function automatic logic retires_in_exec(input iclass_t c);
        return (c == BRANCH_EQ) || (c == BRANCH_NE) || (c == JUMP);
    endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational opcode decoder: instruction class plus the static execute-stage
// control bundle for that class.
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0] opcode,
    output iclass_t    iclass,
    output ctrl_t      ctrl
);

    always_comb begin
        iclass = ILLEGAL;
        ctrl   = CTRL_NONE;
        case (opcode)
            OP_RTYPE: begin
                iclass       = RTYPE;
                ctrl.alu_op  = ALU_FUNCT;
                ctrl.reg_dst = 1'b1;
            end
            OP_LW: begin
                iclass       = LOAD;
                ctrl.alu_op  = ALU_ADD;
                ctrl.alu_src = 1'b1;
                ctrl.ext_op  = 1'b1;
            end
            OP_SW: begin
                iclass       = STORE;
                ctrl.alu_op  = ALU_ADD;
                ctrl.alu_src = 1'b1;
                ctrl.ext_op  = 1'b1;
            end
            OP_ADDI: begin
                iclass       = ADDI;
                ctrl.alu_op  = ALU_ADD;
                ctrl.alu_src = 1'b1;
                ctrl.ext_op  = 1'b1;
            end
            OP_ORI: begin
                iclass       = ORI;
                ctrl.alu_op  = ALU_OR;
                ctrl.alu_src = 1'b1;
            end
            OP_BEQ: begin
                iclass      = BRANCH_EQ;
                ctrl.alu_op = ALU_SUB;
                ctrl.beq    = 1'b1;
            end
            OP_BNE: begin
                iclass      = BRANCH_NE;
                ctrl.alu_op = ALU_SUB;
                ctrl.bne    = 1'b1;
            end
            OP_J: begin
                iclass    = JUMP;
                ctrl.jump = 1'b1;
            end
            default: begin
                iclass = ILLEGAL;
                ctrl   = CTRL_NONE;
            end
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle sequencing FSM for the unpipelined MIPS core: steps each
// instruction through FETCH/DECODE/EXEC/MEM/WB and counts retirements.
module mc_control
    import mc_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [5:0]  i_opcode,
    input  logic        i_imem_ack,
    input  logic        i_dmem_ack,
    output logic        o_imem_req,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic        o_irWrite,
    output logic        o_pcWrite,
    output logic        o_regWrite,
    output logic        o_regDst,
    output logic        o_memToReg,
    output logic        o_ALUSrc,
    output logic [1:0]  o_ALUop,
    output logic        o_jump,
    output logic        o_beq,
    output logic        o_bne,
    output logic        o_extOp,
    output logic        o_illegal,
    output logic [31:0] o_retired
);

    state_t      state;
    iclass_t     cls_q;
    ctrl_t       ctrl_q;
    iclass_t     dec_class;
    ctrl_t       dec_ctrl;

    logic        imem_req_q;
    logic        dmem_req_q;
    logic        dmem_we_q;
    logic        pc_wr_q;
    logic        reg_wr_q;
    logic        mem_to_reg_q;
    logic        illegal_q;
    logic [31:0] retired_q;

    logic        imem_fire;
    logic        dmem_fire;

    mc_decode u_decode (
        .opcode (i_opcode),
        .iclass (dec_class),
        .ctrl   (dec_ctrl)
    );

    // Ack-cycle strobes must follow a zero-wait ack in the same cycle, so they
    // qualify the registered request with the ack; reset masks them.
    assign imem_fire = imem_req_q & i_imem_ack & ~i_rst;
    assign dmem_fire = dmem_req_q & i_dmem_ack & ~i_rst;

    assign o_imem_req = imem_req_q;
    assign o_dmem_req = dmem_req_q;
    assign o_dmem_we  = dmem_we_q;
    assign o_irWrite  = imem_fire;
    assign o_pcWrite  = pc_wr_q | (dmem_fire & dmem_we_q);
    assign o_regWrite = reg_wr_q;
    assign o_memToReg = mem_to_reg_q;
    assign o_regDst   = ctrl_q.reg_dst;
    assign o_ALUSrc   = ctrl_q.alu_src;
    assign o_ALUop    = ctrl_q.alu_op;
    assign o_jump     = ctrl_q.jump;
    assign o_beq      = ctrl_q.beq;
    assign o_bne      = ctrl_q.bne;
    assign o_extOp    = ctrl_q.ext_op;
    assign o_illegal  = illegal_q;
    assign o_retired  = retired_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= FETCH;
            cls_q        <= RTYPE;
            ctrl_q       <= CTRL_NONE;
            imem_req_q   <= 1'b0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            pc_wr_q      <= 1'b0;
            reg_wr_q     <= 1'b0;
            mem_to_reg_q <= 1'b0;
            illegal_q    <= 1'b0;
            retired_q    <= '0;
        end else begin
            pc_wr_q      <= 1'b0;
            reg_wr_q     <= 1'b0;
            mem_to_reg_q <= 1'b0;

            if (o_pcWrite) begin
                retired_q <= retired_q + 32'd1;
            end

            case (state)
                FETCH: begin
                    // Only the first cycle after reset arrives here without a request.
                    if (!imem_req_q) begin
                        imem_req_q <= 1'b1;
                    end else if (i_imem_ack) begin
                        imem_req_q <= 1'b0;
                        state      <= DECODE;
                    end
                end
                DECODE: begin
                    cls_q <= dec_class;
                    if (dec_class == ILLEGAL) begin
                        illegal_q <= 1'b1;
                        state     <= TRAP;
                    end else begin
                        ctrl_q  <= dec_ctrl;
                        pc_wr_q <= retires_in_exec(dec_class);
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    if (retires_in_exec(cls_q)) begin
                        ctrl_q     <= CTRL_NONE;
                        imem_req_q <= 1'b1;
                        state      <= FETCH;
                    end else if ((cls_q == LOAD) || (cls_q == STORE)) begin
                        dmem_req_q <= 1'b1;
                        dmem_we_q  <= (cls_q == STORE);
                        state      <= MEM;
                    end else begin
                        reg_wr_q <= 1'b1;
                        pc_wr_q  <= 1'b1;
                        state    <= WB;
                    end
                end
                MEM: begin
                    if (i_dmem_ack) begin
                        dmem_req_q <= 1'b0;
                        dmem_we_q  <= 1'b0;
                        if (cls_q == STORE) begin
                            ctrl_q     <= CTRL_NONE;
                            imem_req_q <= 1'b1;
                            state      <= FETCH;
                        end else begin
                            reg_wr_q     <= 1'b1;
                            pc_wr_q      <= 1'b1;
                            mem_to_reg_q <= 1'b1;
                            state        <= WB;
                        end
                    end
                end
                WB: begin
                    ctrl_q     <= CTRL_NONE;
                    imem_req_q <= 1'b1;
                    state      <= FETCH;
                end
                TRAP: begin
                    state <= TRAP;
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: each instruction is expanded into a
// per-cycle table of expected outputs and memory acks, then replayed.
module tb_mc_control;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;

    // Expected-output vector layout:
    // {imem_req, dmem_req, dmem_we, irWrite, pcWrite, regWrite, memToReg,
    //  ALUSrc, ALUop[1:0], jump, beq, bne, extOp, regDst, illegal}
    localparam int unsigned B_PCW = 11;

    typedef struct {
        logic [15:0] exp;
        logic        iack;
        logic        dack;
        logic [5:0]  op;
    } cyc_t;

    logic        clk;
    logic        rst;
    logic [5:0]  opcode;
    logic        imem_ack;
    logic        dmem_ack;
    logic        imem_req;
    logic        dmem_req;
    logic        dmem_we;
    logic        ir_write;
    logic        pc_write;
    logic        reg_write;
    logic        reg_dst;
    logic        mem_to_reg;
    logic        alu_src;
    logic [1:0]  alu_op;
    logic        jump;
    logic        beq;
    logic        bne;
    logic        ext_op;
    logic        illegal;
    logic [31:0] retired;

    int unsigned n_checks;
    int unsigned n_fail;
    logic [31:0] exp_retired;
    cyc_t        plan[$];

    mc_control dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_opcode   (opcode),
        .i_imem_ack (imem_ack),
        .i_dmem_ack (dmem_ack),
        .o_imem_req (imem_req),
        .o_dmem_req (dmem_req),
        .o_dmem_we  (dmem_we),
        .o_irWrite  (ir_write),
        .o_pcWrite  (pc_write),
        .o_regWrite (reg_write),
        .o_regDst   (reg_dst),
        .o_memToReg (mem_to_reg),
        .o_ALUSrc   (alu_src),
        .o_ALUop    (alu_op),
        .o_jump     (jump),
        .o_beq      (beq),
        .o_bne      (bne),
        .o_extOp    (ext_op),
        .o_illegal  (illegal),
        .o_retired  (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] observed();
        return {imem_req, dmem_req, dmem_we, ir_write, pc_write, reg_write, mem_to_reg,
                alu_src, alu_op, jump, beq, bne, ext_op, reg_dst, illegal};
    endfunction

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    // {ALUSrc, ALUop, jump, beq, bne, extOp, regDst} straight from the opcode table
    function automatic logic [7:0] exec_ctrl(input logic [5:0] op);
        case (op)
            OP_R:                 return 8'b0_10_000_0_1;
            OP_LW, OP_SW, OP_ADDI: return 8'b1_00_000_1_0;
            OP_ORI:               return 8'b1_11_000_0_0;
            OP_BEQ:               return 8'b0_01_010_0_0;
            OP_BNE:               return 8'b0_01_001_0_0;
            OP_J:                 return 8'b0_00_100_0_0;
            default:              return 8'b0;
        endcase
    endfunction

    task automatic push(input logic [15:0] exp, input logic iack, input logic dack, input logic [5:0] op);
        cyc_t c;
        c.exp  = exp;
        c.iack = iack;
        c.dack = dack;
        c.op   = op;
        plan.push_back(c);
    endtask

    // Fetch (wi wait cycles) and decode; opcode is garbage until the IR loads.
    task automatic plan_front(input logic [5:0] op, input int unsigned wi);
        logic [5:0] g;
        g = 6'($urandom);
        for (int unsigned i = 0; i < wi; i++)
            push({7'b1000000, 8'h00, 1'b0}, 1'b0, rnd(), g);
        push({7'b1001000, 8'h00, 1'b0}, 1'b1, rnd(), g);
        push(16'h0000, rnd(), rnd(), op);
    endtask

    task automatic plan_insn(input logic [5:0] op, input int unsigned wi, input int unsigned wd);
        logic [7:0] c;
        logic       br;
        logic       st;
        logic       ld;
        c  = exec_ctrl(op);
        br = (op == OP_BEQ) || (op == OP_BNE) || (op == OP_J);
        st = (op == OP_SW);
        ld = (op == OP_LW);
        plan_front(op, wi);
        push({4'b0000, br, 2'b00, c, 1'b0}, rnd(), rnd(), op);
        if (st || ld) begin
            for (int unsigned i = 0; i < wd; i++)
                push({1'b0, 1'b1, st, 4'b0000, c, 1'b0}, rnd(), 1'b0, op);
            push({1'b0, 1'b1, st, 1'b0, st, 2'b00, c, 1'b0}, rnd(), 1'b1, op);
        end
        if (!br && !st)
            push({4'b0000, 1'b1, 1'b1, ld, c, 1'b0}, rnd(), rnd(), op);
    endtask

    task automatic plan_illegal(input logic [5:0] op, input int unsigned wi, input int unsigned n_trap);
        plan_front(op, wi);
        for (int unsigned i = 0; i < n_trap; i++)
            push(16'h0001, rnd(), rnd(), 6'($urandom));
    endtask

    task automatic run_plan(input string tag);
        cyc_t c;
        while (plan.size() > 0) begin
            c = plan.pop_front();
            @(negedge clk);
            imem_ack = c.iack;
            dmem_ack = c.dack;
            opcode   = c.op;
            #1;
            check_eq({tag, "_out"}, 32'(observed()), 32'(c.exp));
            check_eq({tag, "_ret"}, retired, exp_retired);
            if (c.exp[B_PCW])
                exp_retired = exp_retired + 32'd1;
        end
    endtask

    // Reset already applied on the preceding edge; hold it and expect all-zero.
    task automatic reset_hold(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(negedge clk);
            imem_ack = rnd();
            dmem_ack = rnd();
            #1;
            check_eq("rst_out", 32'(observed()), 32'h0);
            check_eq("rst_ret", retired, 32'h0);
            if (i == n - 1)
                rst = 1'b0;
        end
        exp_retired = '0;
    endtask

    task automatic do_reset(input int unsigned n);
        @(negedge clk);
        rst = 1'b1;
        reset_hold(n);
    endtask

    initial begin
        logic [5:0] ops [8];
        ops = '{OP_R, OP_LW, OP_SW, OP_ADDI, OP_ORI, OP_BEQ, OP_BNE, OP_J};
        n_checks    = 0;
        n_fail      = 0;
        exp_retired = '0;
        rst         = 1'b1;
        opcode      = '0;
        imem_ack    = 1'b0;
        dmem_ack    = 1'b0;

        do_reset(2);

        // Directed sequence with the latencies called out for each class
        plan_insn(OP_R, 0, 0);
        plan_insn(OP_LW, 0, 3);
        plan_insn(OP_SW, 0, 0);
        plan_insn(OP_BEQ, 0, 0);
        plan_insn(OP_J, 0, 0);
        plan_insn(OP_BNE, 1, 0);
        plan_insn(OP_ORI, 2, 0);
        plan_insn(OP_ADDI, 0, 0);
        plan_insn(OP_SW, 1, 2);
        run_plan("dir");

        for (int unsigned n = 0; n < 60; n++)
            plan_insn(ops[$urandom_range(0, 7)], $urandom_range(0, 2), $urandom_range(0, 3));
        run_plan("rnd");

        // Unknown opcode: sticky trap until reset, then fetch restarts
        plan_illegal(6'b111111, 1, 8);
        run_plan("trap");
        do_reset(2);
        plan_insn(OP_R, 0, 0);
        run_plan("post_trap");

        // Reset during a store's data wait, colliding with its ack
        plan_insn(OP_SW, 0, 6);
        while (plan.size() > 5)
            void'(plan.pop_back());
        run_plan("mid_mem");
        @(negedge clk);
        rst      = 1'b1;
        dmem_ack = 1'b1;
        imem_ack = 1'b0;
        #1;
        check_eq("rst_ack_pcw", 32'(pc_write), 32'h0);
        check_eq("rst_ack_dreq", 32'(dmem_req), 32'h1);
        reset_hold(1);
        plan_insn(OP_LW, 1, 1);
        plan_insn(OP_BEQ, 0, 0);
        run_plan("post_mem_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
